// File: rtl/mux_rate_query_sched_pkg.sv
// Shared types and constants for the monitor query scheduler: FSM states,
// frame length, source encodings and the 10-byte frame builder.
package mux_rate_query_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_ON,
    ST_WAIT_OFF,
    ST_GAP
  } state_e;

  localparam int unsigned FRAME_LEN = 10;
  localparam logic        SRC_HOST  = 1'b0;
  localparam logic        SRC_AUTO  = 1'b1;

  // Header bytes MSB first, then each 12-bit address as two bytes (high nibble zero-padded).
  function automatic logic [79:0] build_frame(input logic [47:0] hdr,
                                              input logic [11:0] start_addr,
                                              input logic [11:0] end_addr);
    return {hdr, 4'h0, start_addr, 4'h0, end_addr};
  endfunction

endpackage

// File: rtl/mux_rate_query_sched_ser.sv
// Control-frame serializer: loads header plus address pair and shifts out
// FRAME_LEN contiguous bytes, pulsing done alongside the last byte.
module rate_query_ser
  import mux_rate_query_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [47:0] hdr,
  input  logic [11:0] start_addr,
  input  logic [11:0] end_addr,
  output logic [7:0]  dout,
  output logic        dout_en,
  output logic        done
);

  logic [79:0] frame_q, frame_d;
  logic [3:0]  cnt_q, cnt_d;

  always_comb begin
    frame_d = frame_q;
    cnt_d   = cnt_q;
    if (load) begin
      frame_d = build_frame(hdr, start_addr, end_addr);
      cnt_d   = 4'(FRAME_LEN);
    end else if (cnt_q != '0) begin
      frame_d = {frame_q[71:0], 8'h00};
      cnt_d   = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_q <= '0;
      cnt_q   <= '0;
    end else begin
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout_en = (cnt_q != '0);
  assign dout    = dout_en ? frame_q[79:72] : '0;
  assign done    = (cnt_q == 4'd1);

endmodule

// File: rtl/mux_rate_query_sched.sv
// Query scheduler in front of the rate monitor: arbitrates host queries against a
// periodic auto-report, serializes the control frame and tracks the response phases.
module mux_rate_query_sched
  import mux_rate_query_sched_pkg::*;
#(
  parameter int unsigned PERIOD_CYC  = 100000000,
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter logic [47:0] AUTO_HDR    = 48'h0,
  parameter logic [11:0] AUTO_END    = 12'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        auto_en,
  input  logic        host_req,
  input  logic [47:0] host_hdr,
  input  logic [11:0] host_start,
  input  logic [11:0] host_end,
  output logic        host_ack,
  output logic        host_err,
  input  logic        rate_din_en,
  input  logic        rate_dout_en,
  output logic [7:0]  con_dout,
  output logic        con_dout_en,
  output logic        busy,
  output logic        last_src,
  output logic        timeout
);

  localparam logic [31:0] TIMER_LAST = 32'(PERIOD_CYC - 1);
  localparam logic [16:0] WAIT_LAST  = 17'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [16:0] wait_cnt_q, wait_cnt_d;
  logic        auto_pend_q, auto_pend_d;
  logic        last_src_q, last_src_d;
  logic        host_ack_q, host_ack_d;
  logic        host_err_q, host_err_d;
  logic        timeout_q, timeout_d;

  logic        idle_free, host_cand, host_bad, auto_cand;
  logic        grant_host, grant_auto, wrap;
  logic        ser_load, ser_done;
  logic [47:0] ser_hdr;
  logic [11:0] ser_start, ser_end;

  // The host still holds host_req during its ack cycle, so it is ignored then
  // to avoid acting twice on one request.
  always_comb begin
    idle_free  = (state_q == ST_IDLE) && !rate_din_en;
    host_cand  = idle_free && host_req && !host_ack_q;
    host_bad   = host_cand && (host_end < host_start);
    auto_cand  = idle_free && auto_pend_q && auto_en;
    grant_host = host_cand && !host_bad && (!auto_cand || last_src_q == SRC_AUTO);
    grant_auto = auto_cand && !grant_host;
    ser_load   = grant_host || grant_auto;
    ser_hdr    = grant_host ? host_hdr   : AUTO_HDR;
    ser_start  = grant_host ? host_start : 12'h000;
    ser_end    = grant_host ? host_end   : AUTO_END;
  end

  always_comb begin
    wrap        = auto_en && (timer_q == TIMER_LAST);
    timer_d     = '0;
    auto_pend_d = 1'b0;
    if (auto_en) begin
      timer_d     = wrap ? '0 : timer_q + 32'd1;
      auto_pend_d = grant_auto ? 1'b0 : (auto_pend_q || wrap);
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    last_src_d = last_src_q;
    host_ack_d = grant_host || host_bad;
    host_err_d = host_bad;
    timeout_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ser_load) begin
          state_d    = ST_SEND;
          last_src_d = grant_host ? SRC_HOST : SRC_AUTO;
        end
      end
      ST_SEND: begin
        if (ser_done) begin
          state_d    = ST_WAIT_ON;
          wait_cnt_d = '0;
        end
      end
      ST_WAIT_ON: begin
        if (rate_dout_en) begin
          state_d    = ST_WAIT_OFF;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 17'd1;
        end
      end
      ST_WAIT_OFF: begin
        if (!rate_dout_en) begin
          state_d = ST_GAP;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 17'd1;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      wait_cnt_q  <= '0;
      auto_pend_q <= 1'b0;
      last_src_q  <= SRC_AUTO;
      host_ack_q  <= 1'b0;
      host_err_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      wait_cnt_q  <= wait_cnt_d;
      auto_pend_q <= auto_pend_d;
      last_src_q  <= last_src_d;
      host_ack_q  <= host_ack_d;
      host_err_q  <= host_err_d;
      timeout_q   <= timeout_d;
    end
  end

  rate_query_ser u_ser (
    .clk        (clk),
    .rst        (rst),
    .load       (ser_load),
    .hdr        (ser_hdr),
    .start_addr (ser_start),
    .end_addr   (ser_end),
    .dout       (con_dout),
    .dout_en    (con_dout_en),
    .done       (ser_done)
  );

  assign host_ack = host_ack_q;
  assign host_err = host_err_q;
  assign busy     = (state_q != ST_IDLE);
  assign last_src = last_src_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_mux_rate_query_sched.sv
// Bench for mux_rate_query_sched: cycle-level reference model with per-cycle
// output comparison, directed scenarios with literal expectations, then random traffic.
module tb_mux_rate_query_sched;

  localparam int unsigned PERIOD = 40;
  localparam int unsigned TO     = 100;
  localparam logic [47:0] AHDR   = 48'hA1A2_A3A4_A5A6;
  localparam logic [11:0] AEND   = 12'h0FF;
  localparam logic [79:0] HOST_FRAME = 80'h0102_0304_0506_0010_001F;

  localparam int P_IDLE = 0, P_SEND = 1, P_WON = 2, P_WOFF = 3, P_GAP = 4;

  logic        clk = 1'b0, rst = 1'b0;
  logic        auto_en = 1'b0, host_req = 1'b0;
  logic [47:0] host_hdr = '0;
  logic [11:0] host_start = '0, host_end = '0;
  logic        rate_din_en = 1'b0, rate_dout_en = 1'b0;
  logic        host_ack, host_err, con_dout_en, busy, last_src, timeout;
  logic [7:0]  con_dout;

  int checks = 0, errors = 0;
  int cyc = 0;
  bit resp_on = 1'b0, resp_rand = 1'b0;
  logic [7:0] fb [10];

  mux_rate_query_sched #(
    .PERIOD_CYC  (PERIOD),
    .TIMEOUT_CYC (TO),
    .AUTO_HDR    (AHDR),
    .AUTO_END    (AEND)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .auto_en      (auto_en),
    .host_req     (host_req),
    .host_hdr     (host_hdr),
    .host_start   (host_start),
    .host_end     (host_end),
    .host_ack     (host_ack),
    .host_err     (host_err),
    .rate_din_en  (rate_din_en),
    .rate_dout_en (rate_dout_en),
    .con_dout     (con_dout),
    .con_dout_en  (con_dout_en),
    .busy         (busy),
    .last_src     (last_src),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] q [$];
  int m_phase, m_wait, m_timer;
  bit m_pend, m_last, e_ack, e_err, e_to;

  task automatic model_reset();
    q.delete();
    m_phase = P_IDLE; m_wait = 0; m_timer = 0;
    m_pend = 0; m_last = 1; e_ack = 0; e_err = 0; e_to = 0;
  endtask

  task automatic push_frame(input logic [47:0] h, input logic [11:0] s, input logic [11:0] e);
    logic [79:0] f;
    f = {h, 4'h0, s, 4'h0, e};
    for (int i = 0; i < 10; i++) q.push_back(f[79-8*i -: 8]);
  endtask

  task automatic model_step();
    bit wrap, a, hok, hbad, ga, nack, nerr, nto;
    wrap = auto_en && (m_timer == PERIOD - 1);
    ga = 0; nack = 0; nerr = 0; nto = 0;
    case (m_phase)
      P_IDLE: if (!rate_din_en) begin
        hok  = host_req && !e_ack && (host_end >= host_start);
        hbad = host_req && !e_ack && (host_end <  host_start);
        a    = m_pend && auto_en;
        if (hbad) begin nack = 1; nerr = 1; end
        if (hok && (!a || m_last)) begin
          push_frame(host_hdr, host_start, host_end);
          m_last = 0; nack = 1; m_phase = P_SEND;
        end else if (a) begin
          push_frame(AHDR, 12'h000, AEND);
          m_last = 1; ga = 1; m_phase = P_SEND;
        end
      end
      P_SEND: begin
        void'(q.pop_front());
        if (q.size() == 0) begin m_phase = P_WON; m_wait = 0; end
      end
      P_WON: begin
        if (rate_dout_en) begin m_phase = P_WOFF; m_wait = 0; end
        else begin
          m_wait++;
          if (m_wait == TO) begin nto = 1; m_phase = P_IDLE; end
        end
      end
      P_WOFF: begin
        if (!rate_dout_en) m_phase = P_GAP;
        else begin
          m_wait++;
          if (m_wait == TO) begin nto = 1; m_phase = P_IDLE; end
        end
      end
      default: m_phase = P_IDLE;
    endcase
    if (!auto_en) begin
      m_timer = 0; m_pend = 0;
    end else begin
      if (ga) m_pend = 0;
      else if (wrap) m_pend = 1;
      m_timer = (m_timer + 1) % PERIOD;
    end
    e_ack = nack; e_err = nerr; e_to = nto;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    chk("con_dout_en", 32'(con_dout_en), 32'(q.size() > 0));
    chk("con_dout", 32'(con_dout), 32'(q.size() > 0 ? q[0] : 8'h00));
    chk("busy", 32'(busy), 32'(m_phase != P_IDLE));
    chk("host_ack", 32'(host_ack), 32'(e_ack));
    chk("host_err", 32'(host_err), 32'(e_err));
    chk("timeout", 32'(timeout), 32'(e_to));
    chk("last_src", 32'(last_src), 32'(m_last));
  end

  // ---------------- monitor responder ----------------
  initial begin : responder
    bit prev_en;
    int lat, len;
    prev_en = 0;
    forever begin
      @(negedge clk);
      if (resp_on && prev_en && !con_dout_en) begin
        lat = 2; len = 3;
        if (resp_rand) begin
          lat = ($urandom_range(0, 19) == 0) ? 120 : int'($urandom_range(0, 15));
          len = ($urandom_range(0, 19) == 0) ? 120 : int'($urandom_range(1, 4));
        end
        repeat (lat + 1) @(posedge clk);
        #2 rate_dout_en = 1'b1;
        repeat (len) @(posedge clk);
        #2 rate_dout_en = 1'b0;
        prev_en = 0;
      end else begin
        prev_en = con_dout_en;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic host_txn(input logic [47:0] h, input logic [11:0] s, input logic [11:0] e);
    int n;
    n = 0;
    host_hdr = h; host_start = s; host_end = e; host_req = 1'b1;
    step();
    while (!host_ack && n < 400) begin step(); n++; end
    chk("host_ack_seen", 32'(host_ack), 32'd1);
    host_req = 1'b0;
  endtask

  task automatic read_frame();
    for (int i = 0; i < 10; i++) begin @(negedge clk); fb[i] = con_dout; end
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    @(negedge clk);
    while (!con_dout_en && n < 400) begin @(negedge clk); n++; end
    chk("frame_start_seen", 32'(con_dout_en), 32'd1);
    fb[0] = con_dout;
    for (int i = 1; i < 10; i++) begin @(negedge clk); fb[i] = con_dout; end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 500) begin step(); n++; end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic check_host_frame(input string tag);
    logic [79:0] hf;
    hf = HOST_FRAME;
    for (int i = 0; i < 10; i++) chk(tag, 32'(fb[i]), 32'(hf[79-8*i -: 8]));
  endtask

  // ---------------- scenarios ----------------
  initial begin : driver
    int t0, n;
    repeat (3) step();
    @(negedge clk);
    chk("rst_con_dout_en", 32'(con_dout_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_last_src", 32'(last_src), 32'd1);
    chk("rst_host_ack", 32'(host_ack), 32'd0);
    step(); rst = 1'b1;

    // contention after update gating: host wins the first tie, auto follows
    resp_on = 1; auto_en = 1; rate_din_en = 1;
    host_hdr = HOST_FRAME[79:32]; host_start = 12'h010; host_end = 12'h01F; host_req = 1;
    repeat (45) step();
    @(negedge clk);
    chk("gated_no_frame", 32'(con_dout_en), 32'd0);
    step(); rate_din_en = 0;
    @(negedge clk);
    chk("no_frame_on_fall_cycle", 32'(con_dout_en), 32'd0);
    step();
    chk("ack_after_fall", 32'(host_ack), 32'd1);
    chk("frame_after_fall", 32'(con_dout_en), 32'd1);
    host_req = 0;
    read_frame();
    check_host_frame("contention_host_byte");
    chk("contention_last_src_host", 32'(last_src), 32'd0);
    wait_frame();
    chk("auto_byte0", 32'(fb[0]), 32'hA1);
    chk("auto_byte6", 32'(fb[6]), 32'h00);
    chk("auto_byte7", 32'(fb[7]), 32'h00);
    chk("auto_byte8", 32'(fb[8]), 32'h00);
    chk("auto_byte9", 32'(fb[9]), 32'hFF);
    chk("contention_last_src_auto", 32'(last_src), 32'd1);
    step(); auto_en = 0;

    // host only
    wait_idle();
    host_txn(HOST_FRAME[79:32], 12'h010, 12'h01F);
    read_frame();
    check_host_frame("host_only_byte");

    // invalid range
    wait_idle();
    host_txn(48'h0, 12'h020, 12'h010);
    chk("invalid_err", 32'(host_err), 32'd1);
    chk("invalid_no_frame", 32'(con_dout_en), 32'd0);
    chk("invalid_busy", 32'(busy), 32'd0);

    // response timeout
    resp_on = 0;
    step(); step();
    host_txn(48'h1111_2222_3333, 12'h005, 12'h005);
    read_frame();
    t0 = cyc; n = 0;
    while (!timeout && n < 300) begin @(negedge clk); n++; end
    chk("timeout_seen", 32'(timeout), 32'd1);
    chk("timeout_delay", 32'(cyc - t0), 32'd101);
    chk("timeout_busy", 32'(busy), 32'd0);
    resp_on = 1;
    step();
    host_txn(48'h7766_5544_3322, 12'h000, 12'h0FF);
    read_frame();
    chk("after_timeout_byte0", 32'(fb[0]), 32'h77);

    // async reset mid-frame, then timer restarts from zero
    wait_idle();
    auto_en = 1;
    host_txn(HOST_FRAME[79:32], 12'h010, 12'h01F);
    repeat (4) step();
    rst = 0;
    #1 chk("reset_drops_en", 32'(con_dout_en), 32'd0);
    step(); step();
    rst = 1;
    t0 = cyc; n = 0;
    @(negedge clk);
    while (!con_dout_en && n < 200) begin @(negedge clk); n++; end
    chk("auto_after_reset_delay", 32'(cyc - t0), 32'(PERIOD + 1));

    // random traffic
    resp_rand = 1;
    for (int k = 0; k < 4000; k++) begin
      step();
      if (host_req && host_ack) host_req = 0;
      else if (host_req && $urandom_range(0, 99) < 2) host_req = 0;
      else if (!host_req && $urandom_range(0, 99) < 8) begin
        host_hdr   = 48'({$urandom(), $urandom()});
        host_start = 12'($urandom_range(0, 4095));
        case ($urandom_range(0, 3))
          0:       host_end = host_start;
          1:       host_end = 12'($urandom_range(0, 4095));
          default: host_end = 12'(host_start + 12'($urandom_range(1, 40)));
        endcase
        host_req = 1;
      end
      if ($urandom_range(0, 99) < 3) rate_din_en = ~rate_din_en;
      if ($urandom_range(0, 999) < 5) auto_en = ~auto_en;
      if ($urandom_range(0, 1999) < 3) begin rst = 0; step(); rst = 1; end
    end

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
